// File: rtl/ps2_mouse_decoder.sv
// Receive-only PS/2 mouse front end: filters the PS/2 clock, deserialises 11-bit frames and
// assembles 3-byte stream packets into deltas, buttons and dead-zoned left/right move levels.
module ps2_mouse_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int DEADZONE       = 4
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iPs2Clk,
    input  logic       iPs2Data,
    output logic       oPacketValid,
    output logic [8:0] oDx,
    output logic [8:0] oDy,
    output logic       oBtnL,
    output logic       oBtnR,
    output logic       oDerecha,
    output logic       oIzquierda,
    output logic       oFrameError
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic signed [8:0] DZ_POS = 9'(DEADZONE);
    localparam logic signed [8:0] DZ_NEG = -DZ_POS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } bitState_t;

    // Synchronisers and clock filter
    logic          clkMeta, clkSync, dataMeta, dataSync;
    logic          filtClk;
    logic [FW-1:0] filtCnt;
    logic          filtFlip;
    logic          fallEdge;

    // Bit FSM
    bitState_t     state, stateNext;
    logic [2:0]    bitCnt, bitCntNext;
    logic [7:0]    shiftReg, shiftNext;
    logic          parityBit, parityNext;
    logic [TW-1:0] toCnt, toCntNext;
    logic          timeout;
    logic          byteOk;
    logic          stopFail;

    // Packet assembler
    logic [1:0]    byteIdx, byteIdxNext;
    logic [7:0]    byte0Reg, byte0Next;
    logic [7:0]    byte1Reg, byte1Next;
    logic          validNext, errNext;
    logic [8:0]    dxNext, dyNext;
    logic          btnLNext, btnRNext, derNext, izqNext;

    // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
    assign filtFlip = (clkSync != filtClk) && (filtCnt == FILT_LAST);
    assign fallEdge = filtFlip && filtClk;

    always_comb begin
        stateNext  = state;
        bitCntNext = bitCnt;
        shiftNext  = shiftReg;
        parityNext = parityBit;
        toCntNext  = toCnt;
        timeout    = 1'b0;
        byteOk     = 1'b0;
        stopFail   = 1'b0;

        if (state == IDLE || fallEdge) begin
            toCntNext = '0;
        end else if (toCnt == TO_LAST) begin
            timeout   = 1'b1;
            toCntNext = '0;
        end else begin
            toCntNext = toCnt + 1'b1;
        end

        if (timeout) begin
            stateNext = IDLE;
        end else if (fallEdge) begin
            case (state)
                IDLE: begin
                    if (!dataSync) begin
                        stateNext  = DATA;
                        bitCntNext = 3'd0;
                    end
                end
                DATA: begin
                    shiftNext  = {dataSync, shiftReg[7:1]};
                    bitCntNext = bitCnt + 3'd1;
                    if (bitCnt == 3'd7) begin
                        stateNext = PARITY;
                    end
                end
                PARITY: begin
                    parityNext = dataSync;
                    stateNext  = STOP;
                end
                STOP: begin
                    if (dataSync && (^{shiftReg, parityBit})) begin
                        byteOk = 1'b1;
                    end else begin
                        stopFail = 1'b1;
                    end
                    stateNext = IDLE;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_comb begin
        byteIdxNext = byteIdx;
        byte0Next   = byte0Reg;
        byte1Next   = byte1Reg;
        validNext   = 1'b0;
        errNext     = 1'b0;
        dxNext      = oDx;
        dyNext      = oDy;
        btnLNext    = oBtnL;
        btnRNext    = oBtnR;
        derNext     = oDerecha;
        izqNext     = oIzquierda;

        if (timeout || stopFail) begin
            errNext     = 1'b1;
            byteIdxNext = 2'd0;
        end else if (byteOk) begin
            case (byteIdx)
                2'd0: begin
                    // Bit 3 is always set in a header byte; anything else means we are out of step.
                    if (shiftReg[3]) begin
                        byte0Next   = shiftReg;
                        byteIdxNext = 2'd1;
                    end else begin
                        errNext = 1'b1;
                    end
                end
                2'd1: begin
                    byte1Next   = shiftReg;
                    byteIdxNext = 2'd2;
                end
                default: begin
                    byteIdxNext = 2'd0;
                    validNext   = 1'b1;
                    btnLNext    = byte0Reg[0];
                    btnRNext    = byte0Reg[1];
                    if (byte0Reg[6]) begin
                        dxNext = byte0Reg[4] ? 9'h100 : 9'h0FF;
                    end else begin
                        dxNext = {byte0Reg[4], byte1Reg};
                    end
                    if (byte0Reg[7]) begin
                        dyNext = byte0Reg[5] ? 9'h100 : 9'h0FF;
                    end else begin
                        dyNext = {byte0Reg[5], shiftReg};
                    end
                    derNext = $signed(dxNext) > DZ_POS;
                    izqNext = $signed(dxNext) < DZ_NEG;
                end
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            clkMeta      <= 1'b1;
            clkSync      <= 1'b1;
            dataMeta     <= 1'b1;
            dataSync     <= 1'b1;
            filtClk      <= 1'b1;
            filtCnt      <= '0;
            state        <= IDLE;
            bitCnt       <= 3'd0;
            shiftReg     <= 8'd0;
            parityBit    <= 1'b0;
            toCnt        <= '0;
            byteIdx      <= 2'd0;
            byte0Reg     <= 8'd0;
            byte1Reg     <= 8'd0;
            oPacketValid <= 1'b0;
            oFrameError  <= 1'b0;
            oDx          <= 9'd0;
            oDy          <= 9'd0;
            oBtnL        <= 1'b0;
            oBtnR        <= 1'b0;
            oDerecha     <= 1'b0;
            oIzquierda   <= 1'b0;
        end else begin
            clkMeta  <= iPs2Clk;
            clkSync  <= clkMeta;
            dataMeta <= iPs2Data;
            dataSync <= dataMeta;

            if (clkSync == filtClk || filtFlip) begin
                filtCnt <= '0;
            end else begin
                filtCnt <= filtCnt + 1'b1;
            end
            if (filtFlip) begin
                filtClk <= ~filtClk;
            end

            state        <= stateNext;
            bitCnt       <= bitCntNext;
            shiftReg     <= shiftNext;
            parityBit    <= parityNext;
            toCnt        <= toCntNext;
            byteIdx      <= byteIdxNext;
            byte0Reg     <= byte0Next;
            byte1Reg     <= byte1Next;
            oPacketValid <= validNext;
            oFrameError  <= errNext;
            oDx          <= dxNext;
            oDy          <= dyNext;
            oBtnL        <= btnLNext;
            oBtnR        <= btnRNext;
            oDerecha     <= derNext;
            oIzquierda   <= izqNext;
        end
    end

endmodule
